axi4_write_req_queue: RTL and testbench

//  Upstream feeder for the AXI4 256-bit writer (writer_* interface). Buffers (address, data)

---
 rtl/axi4_write_req_queue.sv | 157 +++++++++++++++
 tb/tb_axi4_write_req_queue.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_write_req_queue.sv
// axi4_write_req_queue
// Buffers (address, data) write requests from a valid/ready producer in a
// FIFO and hands them one at a time to the 256-bit AXI4 writer through its
// start/ready/done handshake. Tracks occupancy, completed writes and a
// sticky watchdog flag for writes whose done pulse never arrives.
module axi4_write_req_queue #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 256,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [ADDR_W-1:0]      s_addr,
    input  logic [DATA_W-1:0]      s_data,
    output logic                   writer_start,
    output logic [ADDR_W-1:0]      writer_addr,
    output logic [DATA_W-1:0]      writer_data,
    input  logic                   writer_ready,
    input  logic                   writer_idle,
    input  logic                   writer_done,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic [31:0]            done_count,
    output logic                   err_timeout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TIMEOUT_C = TMR_W'(TIMEOUT);

    // ISSUE is the one-cycle gap between popping the head into the writer
    // registers and raising writer_start, so the pulse itself is registered.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [TMR_W-1:0] timer;

    logic push;
    logic pop;
    logic start_next;
    logic done_hit;
    logic timeout_hit;

    // The queue refuses data while in reset and whenever it is full; a pop in
    // the same cycle as a full queue does not open a pass-through path.
    assign s_ready = (fifo_count < DEPTH_C) && !reset;
    assign push    = s_valid && s_ready;
    assign busy    = (fifo_count != '0) || (state != IDLE);

    // Storage array: written on every accepted request, never cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= s_addr;
            data_mem[wr_ptr] <= s_data;
        end
    end

    // Issue FSM decisions: when to pop, when to launch, when a write ends.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        start_next  = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if ((fifo_count != '0) && writer_ready && writer_idle) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                start_next = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (writer_done) begin
                    done_hit   = 1'b1;
                    state_next = IDLE;
                end else if (timer == TIMEOUT_C) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, pointers, writer outputs, watchdog timer and status counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            writer_start <= 1'b0;
            writer_addr  <= '0;
            writer_data  <= '0;
            timer        <= '0;
            done_count   <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_next;
            writer_start <= start_next;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                writer_addr <= addr_mem[rd_ptr];
                writer_data <= data_mem[rd_ptr];
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (start_next) begin
                timer <= TMR_W'(1);
            end else if ((state == WAIT) && (state_next == WAIT)) begin
                timer <= timer + TMR_W'(1);
            end

            if (done_hit) begin
                done_count <= done_count + 32'd1;
            end

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_write_req_queue.sv
// tb_axi4_write_req_queue
// Randomised scoreboard bench for the write request queue. A driver pushes
// requests into an expected-issue queue, a writer model answers starts, and
// a monitor pops the queue on every writer_start and tracks the expected
// done count and watchdog flag from the done/timeout rules.
module tb_axi4_write_req_queue;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 256;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 40;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic              clock;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic              writer_start;
    logic [ADDR_W-1:0] writer_addr;
    logic [DATA_W-1:0] writer_data;
    logic              writer_ready;
    logic              writer_idle;
    logic              writer_done;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;
    logic [31:0]       done_count;
    logic              err_timeout;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;

    logic [319:0] exp_q [$];
    bit           in_flight = 0;
    int           age = 0;
    logic [31:0]  exp_done = 0;
    logic         exp_err = 0;
    int           start_count = 0;
    int           last_start_cyc = 0;

    int done_delay = 3;
    int spur_cnt   = 0;
    int spur_seen  = 0;
    bit w_active   = 0;
    int w_cnt      = 0;
    int w_age      = 0;

    axi4_write_req_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_addr      (s_addr),
        .s_data      (s_data),
        .writer_start(writer_start),
        .writer_addr (writer_addr),
        .writer_data (writer_data),
        .writer_ready(writer_ready),
        .writer_idle (writer_idle),
        .writer_done (writer_done),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .done_count  (done_count),
        .err_timeout (err_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Writer model: acks each start done_delay cycles later (never when 0,
    // in which case it goes idle again once the queue has given up on it).
    initial begin
        writer_done = 1'b0;
        writer_idle = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            writer_done = 1'b0;
            if (reset) begin
                w_active  = 0;
                spur_seen = spur_cnt;
            end else begin
                if (w_active) begin
                    w_age++;
                    if (done_delay != 0) begin
                        w_cnt--;
                        if (w_cnt == 0) begin
                            writer_done = 1'b1;
                            w_active    = 0;
                        end
                    end else if (w_age >= TIMEOUT) begin
                        w_active = 0;
                    end
                end
                if (writer_start) begin
                    w_active = 1;
                    w_cnt    = done_delay;
                    w_age    = 0;
                end
                if (spur_cnt != spur_seen) begin
                    writer_done = 1'b1;
                    spur_seen   = spur_cnt;
                end
            end
            writer_idle = !w_active;
        end
    end

    // Monitor: compare each issued write with the oldest accepted request,
    // then apply the done / watchdog rules for what the next edge will see.
    initial begin
        logic [319:0] e;
        forever begin
            @(negedge clock);
            if (reset) begin
                checkOutput("s_ready_in_reset", s_ready, 1'b0);
                exp_q.delete();
                in_flight = 0;
                age       = 0;
                exp_done  = 0;
                exp_err   = 0;
            end else begin
                if (writer_start) begin
                    start_count++;
                    last_start_cyc = cyc;
                    checkOutput("one_outstanding", in_flight, 1'b0);
                    checkOutput("start_has_request", (exp_q.size() != 0), 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("start_addr", writer_addr, e[319:256]);
                        checkOutput("start_data", writer_data, e[255:0]);
                    end
                    in_flight = 1;
                    age       = 0;
                end
                checkOutput("done_count", done_count, exp_done);
                checkOutput("err_timeout", err_timeout, exp_err);
                if (in_flight) begin
                    if (writer_done) begin
                        exp_done  = exp_done + 32'd1;
                        in_flight = 0;
                    end else if (age + 1 == TIMEOUT) begin
                        exp_err   = 1'b1;
                        in_flight = 0;
                    end else begin
                        age++;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] a, input logic [255:0] d, input int budget, output bit ok);
        ok      = 0;
        s_valid = 1'b1;
        s_addr  = a;
        s_data  = d;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (s_ready) begin
                exp_q.push_back({a, d});
                ok = 1;
            end
            @(posedge clock);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic applyReset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((busy || exp_q.size() != 0) && n < budget);
        checkOutput({name, "_busy"}, busy, 1'b0);
        checkOutput({name, "_sb_empty"}, exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic waitStarts(input string name, input int target, input int budget);
        int n = 0;
        while (start_count < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, (start_count >= target), 1'b1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit           ok;
        int           n_ok;
        int           s0;
        int           push_cyc;
        int           n;
        logic [31:0]  d0;
        logic [255:0] rd;
        logic [63:0]  ra;

        reset        = 1'b1;
        s_valid      = 1'b0;
        s_addr       = '0;
        s_data       = '0;
        writer_ready = 1'b1;
        applyReset(3);

        @(negedge clock);
        checkOutput("rst_s_ready", s_ready, 1'b1);
        checkOutput("rst_fifo_count", fifo_count, 0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_writer_start", writer_start, 1'b0);
        checkOutput("rst_writer_addr", writer_addr, 0);
        checkOutput("rst_writer_data", writer_data, 0);
        @(posedge clock);
        #1;

        $display("[TB] in-order issue of 7 requests, done 3 cycles after start");
        done_delay = 3;
        s0 = start_count;
        applyStimulus(64'd1, 256'd101, 5, ok);
        push_cyc = cyc;
        checkOutput("t1_push_accepted", ok, 1'b1);
        waitStarts("t1_first_start_seen", s0 + 1, 10);
        checkOutput("t1_start_latency", last_start_cyc - push_cyc, 2);
        for (int i = 2; i <= 7; i++) begin
            applyStimulus(64'(i), 256'(100 + i), 50, ok);
            checkOutput("t1_push_accepted", ok, 1'b1);
        end
        waitDrain("t1_drain", 200);
        checkOutput("t1_starts", start_count - s0, 7);
        checkOutput("t1_done_count", done_count, 32'd7);

        $display("[TB] fill with writer not ready, then release");
        done_delay   = 1;
        writer_ready = 1'b0;
        s0   = start_count;
        n_ok = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(64'(200 + i), 256'(1000 + i), 3, ok);
            if (ok) n_ok++;
        end
        @(negedge clock);
        checkOutput("t2_accepted", n_ok, DEPTH);
        checkOutput("t2_s_ready_full", s_ready, 1'b0);
        checkOutput("t2_fifo_count_full", fifo_count, DEPTH);
        checkOutput("t2_no_start", start_count - s0, 0);
        checkOutput("t2_busy_full", busy, 1'b1);
        @(posedge clock);
        #1;
        writer_ready = 1'b1;
        waitDrain("t2_drain", 200);
        checkOutput("t2_starts", start_count - s0, DEPTH);
        checkOutput("t2_fifo_count_empty", fifo_count, 0);

        $display("[TB] writer never completes: watchdog");
        done_delay = 0;
        d0 = done_count;
        s0 = start_count;
        applyStimulus(64'h300, 256'h3000, 5, ok);
        applyStimulus(64'h301, 256'h3001, 5, ok);
        waitStarts("t3_first_start_seen", s0 + 1, 10);
        n = 0;
        while (!err_timeout && n < TIMEOUT + 10) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t3_err_set", err_timeout, 1'b1);
        checkOutput("t3_timeout_cycles", cyc - last_start_cyc, TIMEOUT);
        @(posedge clock);
        #1;
        waitStarts("t3_next_issued", s0 + 2, TIMEOUT + 20);
        waitDrain("t3_drain", 3 * TIMEOUT);
        checkOutput("t3_done_unchanged", done_count, d0);
        checkOutput("t3_err_sticky", err_timeout, 1'b1);
        applyReset(2);
        @(negedge clock);
        checkOutput("t3_err_cleared", err_timeout, 1'b0);
        @(posedge clock);
        #1;

        $display("[TB] 100 random requests pushed while draining");
        done_delay = 1;
        s0   = start_count;
        n_ok = 0;
        for (int i = 0; i < 100; i++) begin
            ra = {$urandom(), $urandom()};
            for (int k = 0; k < 8; k++) rd[k*32 +: 32] = $urandom();
            applyStimulus(ra, rd, 50, ok);
            if (ok) n_ok++;
        end
        checkOutput("t4_accepted", n_ok, 100);
        waitDrain("t4_drain", 1000);
        checkOutput("t4_starts", start_count - s0, 100);
        checkOutput("t4_done_count", done_count, 32'd100);

        $display("[TB] reset while a write is in flight with 5 queued");
        done_delay = 0;
        s0 = start_count;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(64'(500 + i), 256'(5000 + i), 5, ok);
        end
        n = 0;
        while (!(fifo_count == 5 && start_count > s0) && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t5_queued_before_reset", fifo_count, 5);
        @(posedge clock);
        #1;
        applyReset(2);
        spur_cnt++;
        s0 = start_count;
        @(negedge clock);
        checkOutput("t5_fifo_count", fifo_count, 0);
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_writer_start", writer_start, 1'b0);
        checkOutput("t5_s_ready", s_ready, 1'b1);
        repeat (5) @(negedge clock);
        checkOutput("t5_done_count", done_count, 32'd0);
        checkOutput("t5_no_start", start_count - s0, 0);
        @(posedge clock);
        #1;

        $display("[TB] spurious done while idle");
        done_delay = 1;
        d0 = done_count;
        s0 = start_count;
        spur_cnt++;
        repeat (5) @(negedge clock);
        checkOutput("t6_done_unchanged", done_count, d0);
        checkOutput("t6_no_start", start_count - s0, 0);
        checkOutput("t6_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
